// File: rtl/vmx_pkg.sv
// Shared definitions for the matrix-unit tile scheduler: FSM encoding,
// matrix-unit control bit positions and the idle code of the state flag.
package vmx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_IDLE = 3'd3,
      ST_NEXT      = 3'd4,
      ST_DONE      = 3'd5,
      ST_ABORT     = 3'd6
   } state_t;

   localparam int         MX_CTRL_SRST  = 0;
   localparam int         MX_CTRL_START = 1;
   localparam logic [2:0] MX_FLAG_IDLE  = 3'b000;

   function automatic logic mx_is_idle(input logic [2:0] flag);
      return flag == MX_FLAG_IDLE;
   endfunction

endpackage

// File: rtl/vmx_wdog.sv
// Loadable down-counter watchdog; expired is high while the count sits at zero.
module vmx_wdog #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/vmx_tile_sched.sv
// Tile scheduler: walks a job of N tiles through the matrix unit, starting
// each tile, waiting for busy then idle, with watchdog timeouts and host abort.
module vmx_tile_sched
   import vmx_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int CNT_W   = 8,
   parameter int BUSY_TO = 16,
   parameter int DONE_TO = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [ADDR_W-1:0] job_rbase,
   input  logic [ADDR_W-1:0] job_wbase,
   input  logic [ADDR_W-1:0] job_rstride,
   input  logic [ADDR_W-1:0] job_wstride,
   input  logic [CNT_W-1:0]  job_tiles,
   input  logic              abort,
   output logic [ADDR_W-1:0] mx_rbase_addr,
   output logic [ADDR_W-1:0] mx_wbase_addr,
   output logic [31:0]       mx_ctrl,
   input  logic [31:0]       mx_flag,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CNT_W-1:0]  tile_idx
);

   localparam int WD_MAX = (BUSY_TO > DONE_TO) ? BUSY_TO : DONE_TO;
   localparam int WD_W   = $clog2(WD_MAX + 1);
   // Loaded with TO-1 so the state is left after exactly TO cycles in it.
   localparam logic [WD_W-1:0] BUSY_LD = WD_W'(BUSY_TO - 1);
   localparam logic [WD_W-1:0] DONE_LD = WD_W'(DONE_TO - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rbase_q, rbase_d;
   logic [ADDR_W-1:0] wbase_q, wbase_d;
   logic [ADDR_W-1:0] rstride_q, rstride_d;
   logic [ADDR_W-1:0] wstride_q, wstride_d;
   logic [CNT_W-1:0]  tiles_q, tiles_d;
   logic [CNT_W-1:0]  tile_idx_q, tile_idx_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              abrt_cnt_q, abrt_cnt_d;
   logic [CNT_W-1:0]  idx_inc;
   logic              wd_load;
   logic              wd_en;
   logic [WD_W-1:0]   wd_load_val;
   logic              wd_expired;
   logic              flag_idle;
   logic              flag_hi_unused;

   assign flag_idle      = mx_is_idle(mx_flag[2:0]);
   assign flag_hi_unused = ^mx_flag[31:3];

   vmx_wdog #(
      .CNT_W (WD_W)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (wd_load),
      .en       (wd_en),
      .load_val (wd_load_val),
      .expired  (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      rbase_d     = rbase_q;
      wbase_d     = wbase_q;
      rstride_d   = rstride_q;
      wstride_d   = wstride_q;
      tiles_d     = tiles_q;
      tile_idx_d  = tile_idx_q;
      err_d       = err_q;
      done_d      = 1'b0;
      abrt_cnt_d  = abrt_cnt_q;
      wd_load     = 1'b0;
      wd_en       = 1'b0;
      wd_load_val = BUSY_LD;
      idx_inc     = tile_idx_q + CNT_W'(1);

      // Host abort outranks everything, including a timeout in the same cycle.
      if (abort && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
         state_d    = ST_ABORT;
         abrt_cnt_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (job_valid) begin
                  rbase_d    = job_rbase;
                  wbase_d    = job_wbase;
                  rstride_d  = job_rstride;
                  wstride_d  = job_wstride;
                  tiles_d    = job_tiles;
                  tile_idx_d = '0;
                  err_d      = 1'b0;
                  state_d    = (job_tiles == '0) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wd_load     = 1'b1;
               wd_load_val = BUSY_LD;
               state_d     = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               wd_en = 1'b1;
               if (!flag_idle) begin
                  wd_load     = 1'b1;
                  wd_load_val = DONE_LD;
                  state_d     = ST_WAIT_IDLE;
               end else if (wd_expired) begin
                  err_d   = 1'b1;
                  state_d = ST_ABORT;
               end
            end
            ST_WAIT_IDLE: begin
               wd_en = 1'b1;
               if (flag_idle) begin
                  state_d = ST_NEXT;
               end else if (wd_expired) begin
                  err_d   = 1'b1;
                  state_d = ST_ABORT;
               end
            end
            ST_NEXT: begin
               rbase_d    = rbase_q + rstride_q;
               wbase_d    = wbase_q + wstride_q;
               tile_idx_d = idx_inc;
               state_d    = (idx_inc == tiles_q) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_ABORT: begin
               abrt_cnt_d = ~abrt_cnt_q;
               if (abrt_cnt_q) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rbase_q    <= '0;
         wbase_q    <= '0;
         rstride_q  <= '0;
         wstride_q  <= '0;
         tiles_q    <= '0;
         tile_idx_q <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         abrt_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rbase_q    <= rbase_d;
         wbase_q    <= wbase_d;
         rstride_q  <= rstride_d;
         wstride_q  <= wstride_d;
         tiles_q    <= tiles_d;
         tile_idx_q <= tile_idx_d;
         err_q      <= err_d;
         done_q     <= done_d;
         abrt_cnt_q <= abrt_cnt_d;
      end
   end

   always_comb begin
      mx_ctrl                = '0;
      mx_ctrl[MX_CTRL_START] = (state_q == ST_ISSUE);
      mx_ctrl[MX_CTRL_SRST]  = (state_q == ST_ABORT);
   end

   assign job_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign tile_idx      = tile_idx_q;
   assign mx_rbase_addr = rbase_q;
   assign mx_wbase_addr = wbase_q;

endmodule
